cbus_clint: RTL
===============

CBUS_CLINT -- requirements
Module: cbus_clint

Interface
REQ-001 SHALL have parameter BASE, default 64'h0200_0000, CLINT base address.
REQ-002 SHALL have parameter TICK_DIV, default 10, clk cycles per mtime tick; only used when CLINT_PRESCALE_EN is defined.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, cbus_req_t, CBus request (valid, is_write, size, addr, strobe, data, len, burst).
REQ-006 SHALL have port resp, output, cbus_resp_t, CBus response (ready, last, data).
REQ-007 SHALL have port trint, output, 1, timer interrupt to core.
REQ-008 SHALL have port swint, output, 1, software interrupt to core.

Function
REQ-009 SHALL implement 64-bit registers msip (bit 0 only, other bits read 0) at BASE+0x0, mtimecmp at BASE+0x4000, and mtime at BASE+0xBFF8.
REQ-010 SHALL use FSM states IDLE and BEAT; IDLE->BEAT when req.valid=1; BEAT->IDLE after the beat with last=1.
REQ-011 SHALL, on IDLE->BEAT, latch addr, is_write, and len, and clear the beat counter to 0.
REQ-012 SHALL drive resp.ready=1 in every BEAT cycle, giving 1-cycle first-beat latency and one beat per cycle thereafter.
REQ-013 SHALL assert resp.last=1 exactly when the beat counter equals the latched len.
REQ-014 SHALL use address latched_addr + 8*beat for beat n; burst wrap is not supported.
REQ-015 SHALL, on a read beat, return the full 64-bit register at that address; unmapped addresses SHALL return 0.
REQ-016 SHALL, on a write beat, update only the bytes whose req.strobe bit is 1, using req.data; unmapped writes SHALL be ignored.
REQ-017 SHALL increment mtime by 1 per tick, wrapping from 2^64-1 to 0.
REQ-018 SHALL, when a software write to mtime and a tick coincide, store the written value and drop that tick.
REQ-019 SHALL register trint = (mtime >= mtimecmp, unsigned), updated one cycle after any change to either operand.
REQ-020 SHALL register swint = msip[0], updated one cycle after the write.
REQ-021 SHALL keep resp.ready=0, resp.last=0, and resp.data=0 in IDLE.
REQ-022 SHALL, if req.valid falls in BEAT (protocol violation), return to IDLE next cycle and perform no further writes.

Reset
REQ-023 SHALL, while reset=0, force state=IDLE, resp all 0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, trint=0, swint=0, and prescale counter=0.
REQ-024 SHALL, on reset assertion mid-burst, abort the burst immediately; the beats already written SHALL be lost and no further beat issued.
REQ-025 SHALL leave IDLE no earlier than the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, when CLINT_PRESCALE_EN is defined, tick when a prescale counter reaches TICK_DIV-1; the counter SHALL then return to 0.
REQ-027 SHALL, when CLINT_PRESCALE_EN is undefined, tick every clk cycle and contain no prescale counter.

Verification
REQ-028 SHALL test single read: after reset, hold 20 cycles with the macro undefined, then read BASE+0xBFF8 with len=0 -> ready and last on the 2nd cycle, with data in 20..22.
REQ-029 SHALL test strobed write: write mtimecmp with data=64'h1122334455667788 and strobe=8'h0F -> readback 64'hFFFFFFFF55667788.
REQ-030 SHALL test timer interrupt: write mtime=100 and mtimecmp=105 with the macro undefined -> trint rises 5-6 cycles later and stays 1; rewriting mtimecmp=1000 -> trint=0 one cycle later.
REQ-031 SHALL test software interrupt: write 1 to BASE+0x0 -> swint=1 one cycle later; write 0 -> swint=0.
REQ-032 SHALL test burst read: read BASE+0x4000 with len=1 -> beat0 returns mtimecmp, beat1 returns 0 (unmapped) with last=1, then IDLE.
REQ-033 SHALL test reset mid-burst: pull reset low during beat 0 of a 4-beat write -> ready=0 immediately and mtimecmp reads all-ones after reset.

Source files
------------

// File: rtl/cbus_clint.sv
// cbus_clint_pkg + cbus_clint
//
// Core-local interruptor on a CBus slave port. It holds three 64-bit registers:
//   BASE + 0x0000  msip      (only bit 0 is stored; the other bits read as 0)
//   BASE + 0x4000  mtimecmp
//   BASE + 0xBFF8  mtime     (free-running timer that wraps)
// trint is a registered copy of (mtime >= mtimecmp).
// swint is a registered copy of msip[0].
//
// Parameters:
//   BASE      CLINT base address
//   TICK_DIV  clk cycles per mtime tick (used only with the option below)
//
// Build option:
//   CLINT_PRESCALE_EN  when defined, mtime advances once every TICK_DIV clocks.
//                      When undefined, mtime advances every clock and there is
//                      no prescale counter.
//
// Ports:
//   clk        sole clock; all state changes on the rising edge
//   reset      asynchronous, active-low
//   req        CBus request (valid, is_write, size, addr, strobe, data, len, burst)
//   resp       CBus response (ready, last, data)
//   trint      timer interrupt to the core
//   swint      software interrupt to the core
//   dbg_state  current FSM state, for observation only
//
// Handshake (valid/ready):
//   The master raises req.valid while the slave is IDLE. The slave latches
//   addr/is_write/len and enters BEAT on the next edge. From then on every
//   BEAT cycle is one beat, and resp.ready=1 in each of them. resp.last marks
//   the final beat. The master holds req.valid high for the whole burst and
//   presents write data/strobe for beat n during that beat's cycle. It drops
//   req.valid after the cycle that carries last. If valid falls earlier, the
//   burst is abandoned: no further writes happen and the slave goes back to
//   IDLE. resp is all zero outside BEAT.

package cbus_clint_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BEAT = 1'b1
  } clint_state_t;

endpackage

module cbus_clint
  import cbus_clint_pkg::*;
#(
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int          TICK_DIV = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  cbus_req_t    req,
  output cbus_resp_t   resp,
  output logic         trint,
  output logic         swint,
  output clint_state_t dbg_state
);

  localparam logic [63:0] ADDR_MSIP     = BASE;
  localparam logic [63:0] ADDR_MTIMECMP = BASE + 64'h4000;
  localparam logic [63:0] ADDR_MTIME    = BASE + 64'hBFF8;

  clint_state_t state, state_next;

  logic [63:0] lat_addr;
  logic        lat_write;
  logic [7:0]  lat_len;
  logic [7:0]  beat;

  logic        msip;
  logic [63:0] mtimecmp;
  logic [63:0] mtime;
  logic        tick;

  logic [63:0] beat_addr;
  logic        is_last;
  logic        wr_fire;
  logic        hit_msip;
  logic        hit_cmp;
  logic        hit_time;
  logic [63:0] rdata;

  // size and burst carry no meaning here: every beat is a full 64-bit word
  // and the address always steps by 8.
  logic unused_req;
  assign unused_req = ^{req.size, req.burst};

  // Byte-lane merge: only the lanes selected by strb take the new data.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Beat n addresses lat_addr + 8*n. Wrap bursts are not supported.
  assign beat_addr = lat_addr + {53'd0, beat, 3'b000};
  assign is_last   = (beat == lat_len);
  assign hit_msip  = (beat_addr == ADDR_MSIP);
  assign hit_cmp   = (beat_addr == ADDR_MTIMECMP);
  assign hit_time  = (beat_addr == ADDR_MTIME);

  // A write lands only while the master still holds valid. This is what
  // makes an abandoned burst harmless.
  assign wr_fire = (state == ST_BEAT) && req.valid && lat_write;

  always_comb begin
    rdata = 64'd0;
    if (hit_msip)      rdata = {63'd0, msip};
    else if (hit_cmp)  rdata = mtimecmp;
    else if (hit_time) rdata = mtime;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    resp       = '0;
    case (state)
      ST_IDLE: begin
        if (req.valid) state_next = ST_BEAT;
      end
      ST_BEAT: begin
        resp.ready = 1'b1;
        resp.last  = is_last;
        resp.data  = lat_write ? 64'd0 : rdata;
        if (!req.valid || is_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign dbg_state = state;

  // Burst context: latched at the start of a burst, then advanced per beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_addr  <= 64'd0;
      lat_write <= 1'b0;
      lat_len   <= 8'd0;
      beat      <= 8'd0;
    end else if (state == ST_IDLE) begin
      if (req.valid) begin
        lat_addr  <= req.addr;
        lat_write <= req.is_write;
        lat_len   <= req.len;
        beat      <= 8'd0;
      end
    end else if (req.valid && !is_last) begin
      beat <= beat + 8'd1;
    end
  end

  // ---------------- tick source ----------------
`ifdef CLINT_PRESCALE_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_cnt;

  assign tick = (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end
`else
  // TICK_DIV has no effect in this build.
  logic unused_tick_div;
  assign unused_tick_div = ^TICK_DIV;
  assign tick = 1'b1;
`endif

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msip     <= 1'b0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr_fire) begin
      if (hit_msip && req.strobe[0]) msip <= req.data[0];
      if (hit_cmp) mtimecmp <= merge_bytes(mtimecmp, req.data, req.strobe);
    end
  end

  // A software write to mtime wins over a coincident tick. That tick is lost,
  // not deferred.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                mtime <= 64'd0;
    else if (wr_fire && hit_time) mtime <= merge_bytes(mtime, req.data, req.strobe);
    else if (tick)             mtime <= mtime + 64'd1;
  end

  // Both interrupts follow their source registers by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trint <= 1'b0;
      swint <= 1'b0;
    end else begin
      trint <= (mtime >= mtimecmp);
      swint <= msip;
    end
  end

endmodule
